// File: rtl/arb_pkg.sv
// Shared types and encodings for the round-robin / fixed priority arbiter.
package arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/rr_pick.sv
// Combinational masked priority picker: first set request at or after the
// start index (ptr in round-robin mode, 0 in fixed mode), wrapping mod N.
module rr_pick
    import arb_pkg::*;
#(
    parameter int unsigned N    = 4,
    parameter int unsigned IDXW = $clog2(N)
) (
    input  logic [N-1:0]    i_req,
    input  logic [IDXW-1:0] i_ptr,
    input  logic            i_mode,
    output logic [N-1:0]    o_grant,
    output logic [IDXW-1:0] o_idx
);

    logic [IDXW-1:0] w_start;
    logic [N-1:0]    w_rot;
    logic            w_found;
    int unsigned     w_pos;

    // Rotate a doubled request vector so the search always starts at bit 0,
    // then map the first hit back to an absolute requester index.
    always_comb begin
        w_start = (i_mode == MODE_RR) ? i_ptr : '0;
        w_rot   = N'({i_req, i_req} >> w_start);
        w_found = 1'b0;
        w_pos   = 0;
        o_grant = '0;
        o_idx   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (!w_found && w_rot[k]) begin
                w_found = 1'b1;
                w_pos   = 32'(w_start) + k;
                if (w_pos >= N) begin
                    w_pos = w_pos - N;
                end
                o_idx          = IDXW'(w_pos);
                o_grant[o_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_priority_arbiter.sv
// N-requester arbiter with registered one-hot grant, fixed or round-robin
// policy, grant hold until release/withdrawal and optional hold timeout.
module rr_priority_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned N        = 4,
    parameter int unsigned IDXW     = $clog2(N),
    parameter int unsigned MAX_HOLD = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req,
    input  logic            mode,
    input  logic            release_i,
    output logic [N-1:0]    grant,
    output logic            grant_valid,
    output logic [IDXW-1:0] grant_idx,
    output logic            timeout
);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [N-1:0]    r_grant;
    logic            r_valid;
    logic [IDXW-1:0] r_idx;
    logic            r_timeout;
    logic [IDXW-1:0] r_ptr;
    logic            r_mode;

    logic [N-1:0]    w_pick_gnt;
    logic [IDXW-1:0] w_pick_idx;
    logic            w_lim;
    logic            w_end;

    logic [N-1:0]    w_grant_nxt;
    logic [IDXW-1:0] w_idx_nxt;
    logic            w_to_nxt;
    logic [IDXW-1:0] w_ptr_nxt;
    logic            w_mode_nxt;

    rr_pick #(
        .N    (N),
        .IDXW (IDXW)
    ) u_pick (
        .i_req   (req),
        .i_ptr   (r_ptr),
        .i_mode  (mode),
        .o_grant (w_pick_gnt),
        .o_idx   (w_pick_idx)
    );

    generate
        if (MAX_HOLD > 0) begin : g_hold
            localparam int unsigned HCW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD + 1) : 1;
            logic [HCW-1:0] r_hold;

            // Hold counter: zero while idle so it starts at 0 on grant entry, saturates.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_hold <= '0;
                end else if (r_state == IDLE) begin
                    r_hold <= '0;
                end else if (r_hold != '1) begin
                    r_hold <= r_hold + 1'b1;
                end
            end

            assign w_lim = (r_hold == HCW'(MAX_HOLD - 1));
        end else begin : g_nohold
            assign w_lim = 1'b0;
        end
    endgenerate

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: arbitrate in IDLE, leave GRANT on any end condition.
    always_comb begin
        w_end       = (r_state == GRANT) && (release_i || !req[r_idx] || w_lim);
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (req != '0) w_state_nxt = GRANT;
            GRANT:   if (w_end)     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Output logic: next values for the registered outputs and the pointer.
    // Timeout only when the hold limit is the sole reason the grant ends.
    always_comb begin
        w_grant_nxt = r_grant;
        w_idx_nxt   = r_idx;
        w_to_nxt    = 1'b0;
        w_ptr_nxt   = r_ptr;
        w_mode_nxt  = r_mode;
        if (r_state == IDLE) begin
            w_grant_nxt = w_pick_gnt;
            w_idx_nxt   = w_pick_idx;
            w_mode_nxt  = mode;
        end else if (w_end) begin
            w_grant_nxt = '0;
            w_idx_nxt   = '0;
            w_to_nxt    = w_lim && !release_i && req[r_idx];
            if (r_mode == MODE_RR) begin
                w_ptr_nxt = (r_idx == IDXW'(N - 1)) ? '0 : r_idx + 1'b1;
            end
        end
    end

    // Output and pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant   <= '0;
            r_valid   <= 1'b0;
            r_idx     <= '0;
            r_timeout <= 1'b0;
            r_ptr     <= '0;
            r_mode    <= MODE_FIXED;
        end else begin
            r_grant   <= w_grant_nxt;
            r_valid   <= |w_grant_nxt;
            r_idx     <= w_idx_nxt;
            r_timeout <= w_to_nxt;
            r_ptr     <= w_ptr_nxt;
            r_mode    <= w_mode_nxt;
        end
    end

    assign grant       = r_grant;
    assign grant_valid = r_valid;
    assign grant_idx   = r_idx;
    assign timeout     = r_timeout;

endmodule

// File: doc/rr_priority_arbiter.md
# rr_priority_arbiter

Parametrised N-requester arbiter that succeeds the 4-bit combinational priority generator with registered grants, a selectable fixed/round-robin policy, grant hold with release handshake and an optional hold timeout. It sits between N request sources and a single shared resource and issues one one-hot grant at a time.

## Interface
- `N`, 4: number of requesters, N ≥ 2.
- `IDXW`, $clog2(N): width of the grant index.
- `MAX_HOLD`, 0: maximum grant length in cycles. 0 means unlimited.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req`  in  N  request vector. Bit i is requester i. Level-sensitive.
- `mode`  in  1  0 = fixed priority (bit 0 highest), 1 = round-robin.
- `release_i`  in  1  holder is done. Sampled only in GRANT.
- `grant`  out  N  registered one-hot grant, or all zero.
- `grant_valid`  out  1  equals |grant.
- `grant_idx`  out  IDXW  index of the granted requester. 0 when no grant.
- `timeout`  out  1  one-cycle pulse when a grant is revoked by MAX_HOLD.

## Operation
- FSM states: IDLE, GRANT.
- IDLE:
  - If req != 0, compute the winner, register grant/grant_idx and go to GRANT.
  - Otherwise stay in IDLE with grant = 0.
- Winner, fixed mode: the lowest set index of req.
- Winner, round-robin mode: the first set bit at index ptr, ptr+1, … mod N (wraps N-1 → 0).
- GRANT: the grant is held stable. The grant ends at the edge where any of these is true:
  - release_i = 1,
  - req[grant_idx] = 0 (requester withdrew),
  - MAX_HOLD ≠ 0 and hold_cnt = MAX_HOLD-1.
- On grant end:
  - grant clears and the FSM returns to IDLE.
  - There is always one idle bubble cycle between consecutive grants.
- Pointer ptr (IDXW bits, reset 0):
  - In round-robin mode it updates on grant end to (grant_idx+1) mod N.
  - In fixed mode it is not modified.
- hold_cnt:
  - Cleared on entry to GRANT, increments each GRANT cycle.
  - Saturating width $clog2(MAX_HOLD+1). Not present when MAX_HOLD = 0.
- timeout pulses high for the one cycle after revocation by the hold limit only, not for release or withdrawal.
- Simultaneous events: release_i together with the hold limit counts as release, so no timeout pulse.
- mode is sampled only in IDLE when arbitrating. Changing it during GRANT has no effect on the current grant.
- Changes to req bits other than grant_idx during GRANT are ignored.

## Timing
- Reset (async assert, sync-released internally by the flop edge):
  - state = IDLE, grant = 0, grant_valid = 0, grant_idx = 0, timeout = 0, ptr = 0, hold_cnt = 0.
- Reset mid-grant: outputs go to their reset values immediately, with no release cycle.
- Latency from req sampled in IDLE at edge k to grant visible: after edge k (1 cycle).
- Latency from grant end (release/withdraw/timeout) sampled at edge k to grant = 0: after edge k.
- Earliest next grant: after edge k+1.
- Minimum grant length is 1 cycle.
- With MAX_HOLD = M the grant lasts exactly M cycles unless ended earlier.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- A shared package `arb_pkg` holds:
  - the state enum (IDLE, GRANT),
  - the mode encodings (MODE_FIXED = 0, MODE_RR = 1).
- Sub-module `rr_pick`: combinational N-bit masked priority picker. It takes (req, ptr, mode) and returns one-hot winner and winner index.
  - Implementation: double-width (req,req) search starting from ptr.
  - Used once by the top, which contains the FSM, ptr, hold_cnt and output registers.

## Test plan
- Reset and fixed mode, N=4: hold rst_n low and check all outputs are 0. Release reset, mode=0, req=4'b1010 → next cycle grant=4'b0010, grant_idx=1.
- Round-robin rotation, N=4, mode=1: req=4'b1111 held, release_i pulsed in each GRANT cycle → grant_idx sequence 0,1,2,3,0 with one bubble cycle between grants.
- Wrap-around, mode=1: after a grant to 3 (ptr=0), req=4'b1001 → grant_idx=0. Then req=4'b1001 again → grant_idx=3.
- Withdrawal: grant to idx 2, drop req[2] → grant=0 next cycle, timeout stays 0. With mode=1, ptr=3.
- Timeout, MAX_HOLD=3: req=4'b0100 held, release_i=0 → grant high for exactly 3 cycles, then timeout=1 for one cycle, then a regrant to idx 2 after the bubble. Release_i asserted in the third cycle → no timeout pulse.
- Reset mid-grant: while grant=4'b1000, assert rst_n=0 asynchronously between edges → grant=0 and grant_idx=0 immediately. After release with req=4'b1111 and mode=1 → grant_idx=0 (ptr reset).
